// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit -- execute-stage multiply/divide unit with architectural HI/LO.
//
// mult/multu/mthi/mtlo complete in one cycle. div/divu run a DATA_W-step
// restoring divider and hold the pipeline with busy until the result is
// ready. HI/LO feed the mfhi/mflo writeback path.
//
// Ports:
//   clk       in   pipeline clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   md_ctrl   in   {mult,multu,div,divu,mthi,mtlo}; one-hot or zero
//   src_a     in   rs operand (dividend / multiplicand / mthi-mtlo data)
//   src_b     in   rt operand (divisor / multiplier)
//   ex_flush  in   cancels the instruction currently in EX
//   hi, lo    out  HI / LO registers
//   busy      out  stall request to IF/ID and ID/EX
//   div_done  out  one-cycle pulse while the divide result is committed
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        md_ctrl,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              ex_flush,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              div_done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0]  counter_reg;
    logic [DATA_W-1:0] divisor_reg;
    logic [DATA_W-1:0] quot_reg;
    logic [DATA_W-1:0] rem_reg;
    logic [DATA_W-1:0] dividend_reg;
    logic              q_neg_reg;
    logic              r_neg_reg;
    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;

    // ------------------------------------------------------------------
    // Operation decode; if an illegal multi-hot pattern arrives the
    // leftmost bit wins.
    // ------------------------------------------------------------------
    logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
    logic start_div;

    always_comb begin
        op_mult  = 1'b0;
        op_multu = 1'b0;
        op_div   = 1'b0;
        op_divu  = 1'b0;
        op_mthi  = 1'b0;
        op_mtlo  = 1'b0;
        if (md_ctrl[5])      op_mult  = 1'b1;
        else if (md_ctrl[4]) op_multu = 1'b1;
        else if (md_ctrl[3]) op_div   = 1'b1;
        else if (md_ctrl[2]) op_divu  = 1'b1;
        else if (md_ctrl[1]) op_mthi  = 1'b1;
        else if (md_ctrl[0]) op_mtlo  = 1'b1;
    end

    assign start_div = op_div | op_divu;

    // ------------------------------------------------------------------
    // Operand preparation
    // ------------------------------------------------------------------
    logic [2*DATA_W-1:0] prod_s, prod_u;
    logic                sign_a, sign_b;
    logic [DATA_W-1:0]   abs_a, abs_b;

    // Operands are widened to the full product width so the low 2*DATA_W
    // bits of the product are the exact signed/unsigned result.
    assign prod_s = {{DATA_W{src_a[DATA_W-1]}}, src_a} * {{DATA_W{src_b[DATA_W-1]}}, src_b};
    assign prod_u = {{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b};

    assign sign_a = op_div & src_a[DATA_W-1];
    assign sign_b = op_div & src_b[DATA_W-1];
    // Negating the most negative value yields itself, which read as
    // unsigned is exactly its magnitude.
    assign abs_a  = sign_a ? ({DATA_W{1'b0}} - src_a) : src_a;
    assign abs_b  = sign_b ? ({DATA_W{1'b0}} - src_b) : src_b;

    // ------------------------------------------------------------------
    // One restoring step. The shifted remainder needs DATA_W+1 bits; when
    // it is not below the divisor the difference fits in DATA_W bits.
    // ------------------------------------------------------------------
    logic [DATA_W:0]   rem_shift;
    logic              step_ge;
    logic [DATA_W-1:0] trial;

    assign rem_shift = {rem_reg, quot_reg[DATA_W-1]};
    assign step_ge   = (rem_shift >= {1'b0, divisor_reg});
    assign trial     = rem_shift[DATA_W-1:0] - divisor_reg;

    // ------------------------------------------------------------------
    // Sign fix-up. A zero divisor bypasses it: the unsigned loop yields an
    // all-ones quotient and HI returns the untouched dividend.
    // ------------------------------------------------------------------
    logic              div_by_zero;
    logic [DATA_W-1:0] quot_fix, rem_fix;

    assign div_by_zero = (divisor_reg == {DATA_W{1'b0}});
    assign quot_fix = div_by_zero ? quot_reg
                    : (q_neg_reg ? ({DATA_W{1'b0}} - quot_reg) : quot_reg);
    assign rem_fix  = div_by_zero ? dividend_reg
                    : (r_neg_reg ? ({DATA_W{1'b0}} - rem_reg) : rem_reg);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        if (ex_flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:     if (start_div) state_next = DIV_RUN;
                DIV_RUN:  if (counter_reg == LAST_STEP) state_next = DIV_DONE;
                // The div is still on md_ctrl here; it must not re-issue.
                DIV_DONE: state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy     = 1'b0;
        div_done = 1'b0;
        case (state_reg)
            IDLE:     busy     = start_div;
            DIV_RUN:  busy     = 1'b1;
            DIV_DONE: div_done = 1'b1;
            default:  ;
        endcase
        // A flushed instruction must not stall; reset clears any stall.
        if (ex_flush || !rst_n) begin
            busy = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Divider datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_reg  <= '0;
            divisor_reg  <= '0;
            quot_reg     <= '0;
            rem_reg      <= '0;
            dividend_reg <= '0;
            q_neg_reg    <= 1'b0;
            r_neg_reg    <= 1'b0;
        end else if (!ex_flush) begin
            case (state_reg)
                IDLE: begin
                    if (start_div) begin
                        divisor_reg  <= abs_b;
                        quot_reg     <= abs_a;
                        rem_reg      <= '0;
                        dividend_reg <= src_a;
                        q_neg_reg    <= sign_a ^ sign_b;
                        r_neg_reg    <= sign_a;
                        counter_reg  <= '0;
                    end
                end
                DIV_RUN: begin
                    rem_reg     <= step_ge ? trial : rem_shift[DATA_W-1:0];
                    quot_reg    <= {quot_reg[DATA_W-2:0], step_ge};
                    counter_reg <= counter_reg + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // HI/LO architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (!ex_flush) begin
            case (state_reg)
                IDLE: begin
                    if (op_mult) begin
                        {hi_reg, lo_reg} <= prod_s;
                    end else if (op_multu) begin
                        {hi_reg, lo_reg} <= prod_u;
                    end else if (op_mthi) begin
                        hi_reg <= src_a;
                    end else if (op_mtlo) begin
                        lo_reg <= src_a;
                    end
                end
                DIV_DONE: begin
                    lo_reg <= quot_fix;
                    hi_reg <= rem_fix;
                end
                default: ;
            endcase
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit -- directed self-checking bench for md_unit.
// ---------------------------------------------------------------------------
module tb_md_unit;

    localparam logic [5:0] C_MULT  = 6'b100000;
    localparam logic [5:0] C_MULTU = 6'b010000;
    localparam logic [5:0] C_DIV   = 6'b001000;
    localparam logic [5:0] C_DIVU  = 6'b000100;
    localparam logic [5:0] C_MTHI  = 6'b000010;
    localparam logic [5:0] C_MTLO  = 6'b000001;

    logic        clk;
    logic        rst_n;
    logic [5:0]  md_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        ex_flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        div_done;

    int tests_run;
    int tests_failed;
    int busy_cycles;
    int done_pulses;
    int saw_busy;

    md_unit #(.DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_ctrl  (md_ctrl),
        .src_a    (src_a),
        .src_b    (src_b),
        .ex_flush (ex_flush),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .div_done (div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a divide held on md_ctrl until it commits; checks busy length,
    // the done pulse, HI/LO holding before commit, result after commit and
    // that the still-present div does not restart.
    task automatic run_div(input string tag, input logic [5:0] ctrl,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] old_hi, input logic [31:0] old_lo,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        md_ctrl = ctrl;
        src_a   = a;
        src_b   = b;
        busy_cycles = 0;
        @(negedge clk);
        while (busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
        chk({tag, "_done_pulse"}, {31'd0, div_done}, 32'd1);
        chk({tag, "_hi_hold"}, hi, old_hi);
        chk({tag, "_lo_hold"}, lo, old_lo);
        step();
        md_ctrl = 6'b0;
        #1;
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_done_clear"}, {31'd0, div_done}, 32'd0);
        step();
        chk({tag, "_no_restart"}, {31'd0, busy}, 32'd0);
        $display("[TB] %s a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", tag, a, b, hi, lo, busy_cycles);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n    = 1'b0;
        md_ctrl  = 6'b0;
        src_a    = 32'h0;
        src_b    = 32'h0;
        ex_flush = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, div_done}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // mult (-1 * 2 = -2)
        md_ctrl = C_MULT; src_a = 32'hFFFF_FFFF; src_b = 32'h2;
        @(negedge clk);
        chk("mult_busy", {31'd0, busy}, 32'd0);
        step();
        md_ctrl = 6'b0;
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);
        $display("[TB] mult -> hi=%h lo=%h", hi, lo);

        // multu (0xFFFFFFFF * 2)
        md_ctrl = C_MULTU;
        @(negedge clk);
        chk("multu_busy", {31'd0, busy}, 32'd0);
        step();
        md_ctrl = 6'b0;
        chk("multu_hi", hi, 32'h1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        $display("[TB] multu -> hi=%h lo=%h", hi, lo);

        // Signed divides and divide-by-zero
        run_div("div_m7_2", C_DIV, 32'hFFFF_FFF9, 32'h2,
                32'h1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("divu_100_7", C_DIVU, 32'd100, 32'd7,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h2, 32'hE);
        run_div("div_min_m1", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h2, 32'hE, 32'h0, 32'h8000_0000);
        run_div("divu_by_0", C_DIVU, 32'h1234, 32'h0,
                32'h0, 32'h8000_0000, 32'h1234, 32'hFFFF_FFFF);

        // mthi then mtlo on consecutive cycles
        saw_busy = 0;
        md_ctrl = C_MTHI; src_a = 32'hA5A5_A5A5;
        @(negedge clk);
        if (busy !== 1'b0) saw_busy++;
        step();
        md_ctrl = C_MTLO; src_a = 32'h5A5A_5A5A;
        chk("mthi_hi", hi, 32'hA5A5_A5A5);
        chk("mthi_lo_kept", lo, 32'hFFFF_FFFF);
        @(negedge clk);
        if (busy !== 1'b0) saw_busy++;
        step();
        md_ctrl = 6'b0;
        chk("mtlo_lo", lo, 32'h5A5A_5A5A);
        chk("mtlo_hi_kept", hi, 32'hA5A5_A5A5);
        chk("mthi_mtlo_busy", 32'(saw_busy), 32'd0);
        $display("[TB] mthi/mtlo -> hi=%h lo=%h", hi, lo);

        // Illegal multi-hot: mthi outranks mtlo
        md_ctrl = C_MTHI | C_MTLO; src_a = 32'h1357_9BDF;
        step();
        md_ctrl = 6'b0;
        chk("prio_hi", hi, 32'h1357_9BDF);
        chk("prio_lo", lo, 32'h5A5A_5A5A);
        $display("[TB] mthi|mtlo -> hi=%h lo=%h", hi, lo);
        md_ctrl = C_MTHI; src_a = 32'hA5A5_A5A5;
        step();
        md_ctrl = 6'b0;

        // Flush on the 10th DIV_RUN cycle
        md_ctrl = C_DIV; src_a = 32'd100; src_b = 32'd7;
        step();                     // issue edge -> 1st run cycle
        repeat (9) step();          // now in 10th run cycle
        ex_flush = 1'b1;
        @(negedge clk);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        step();
        ex_flush = 1'b0;
        md_ctrl  = 6'b0;
        saw_busy = 0;
        done_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) saw_busy++;
            if (div_done === 1'b1) done_pulses++;
        end
        chk("flush_no_busy", 32'(saw_busy), 32'd0);
        chk("flush_no_done", 32'(done_pulses), 32'd0);
        chk("flush_hi", hi, 32'hA5A5_A5A5);
        chk("flush_lo", lo, 32'h5A5A_5A5A);
        $display("[TB] flushed div -> hi=%h lo=%h", hi, lo);

        // Asynchronous reset mid-divide
        step();
        md_ctrl = C_DIVU; src_a = 32'd1000; src_b = 32'd3;
        repeat (6) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_hi", hi, 32'h0);
        chk("areset_lo", lo, 32'h0);
        chk("areset_busy", {31'd0, busy}, 32'd0);
        $display("[TB] async reset mid-div -> hi=%h lo=%h busy=%b", hi, lo, busy);
        md_ctrl = 6'b0;
        step();
        rst_n = 1'b1;
        step();
        run_div("divu_9_3", C_DIVU, 32'd9, 32'd3,
                32'h0, 32'h0, 32'h0, 32'h3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Consumes the mult/multu/div/divu/mthi/mtlo bits (exe_ctrl[13:8]) produced by the decode-stage control, plus forwarded rs/rt operands.
- Multiply and mthi/mtlo complete in one cycle. Divide is a 32-iteration restoring divider that stalls the pipeline via busy.
- HI/LO outputs feed the mfhi/mflo writeback path.

Parameters:
- DATA_W, 32: operand and HI/LO width; divide iteration count equals DATA_W.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- md_ctrl  in  6  {mult,multu,div,divu,mthi,mtlo} = exe_ctrl[13:8]; one-hot or zero.
- src_a  in  DATA_W  rs operand after forwarding (dividend / multiplicand / mthi-mtlo data).
- src_b  in  DATA_W  rt operand after forwarding (divisor / multiplier).
- ex_flush  in  1  cancels the instruction currently in EX (exception or eret).
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.
- busy  out  1  stall request to the ID/EX and IF/ID stages.
- div_done  out  1  1-cycle pulse in DONE state.

Behaviour:
- Reset (rst_n=0, asynchronous): hi=0, lo=0, state=IDLE, counter=0, busy=0, div_done=0. Any operation in flight is discarded.
- Decode priority if more than one md_ctrl bit is set (illegal): mult > multu > div > divu > mthi > mtlo.
- ex_flush=1 in any state:
  - No HI/LO write at that edge.
  - Next state is IDLE.
  - busy is forced to 0 combinationally that cycle.
- States: IDLE, DIV_RUN, DIV_DONE.
- IDLE:
  - mult: at the edge, {hi,lo} <= signed 64-bit product of src_a and src_b. busy=0.
  - multu: same, unsigned product.
  - mthi: hi <= src_a. mtlo: lo <= src_a. The other register is unchanged.
  - div/divu: busy=1 combinationally in the issue cycle. At the edge:
    - Latch |src_a| and |src_b| (plain values for divu); magnitude of 0x80000000 is 0x80000000 unsigned.
    - Latch the quotient sign (sign_a XOR sign_b, div only) and the remainder sign (sign_a, div only).
    - Latch the original src_a; clear partial remainder; counter=0; go to DIV_RUN.
- DIV_RUN:
  - busy=1.
  - Each edge performs one restoring step: shift {rem,quot} left one bit, trial-subtract the divisor, set the quotient bit if no borrow.
  - counter increments; after the DATA_W-th step (counter reaches DATA_W-1 and steps), go to DIV_DONE.
  - md_ctrl is ignored (the stall holds the same div in EX).
- DIV_DONE:
  - busy=0, div_done=1.
  - At the edge: lo <= sign-corrected quotient, hi <= sign-corrected remainder; go to IDLE.
  - The div still present on md_ctrl this cycle must not restart.
- Timing:
  - busy is high for exactly DATA_W+1 cycles (33): issue cycle plus 32 run cycles.
  - HI/LO update at the 34th edge after the cycle containing the issue edge.
  - The following instruction leaves ID/EX at the same edge.
- Signed fix-up:
  - Quotient is negated (two's complement) if the quotient sign is set.
  - Remainder is negated if the dividend was negative.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (div or divu):
  - Full latency.
  - lo=0xFFFFFFFF, hi=original src_a (unsigned algorithm result, no sign fix-up).
  - No exception raised.
- mult/multu/mthi/mtlo never assert busy. Back-to-back single-cycle ops each write on consecutive edges.
- hi/lo change only at the edges listed above. No other path writes them.

Test Plan:
- Reset, then mult with src_a=0xFFFFFFFF, src_b=0x2 -> after 1 edge hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy never 1. Same operands with multu -> hi=0x1, lo=0xFFFFFFFE.
- div with src_a=0xFFFFFFF9 (-7), src_b=0x2 -> busy high for 33 consecutive cycles, div_done pulses once, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=0xE, hi=0x2.
- div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. divu 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234 after the full 33-cycle busy.
- mthi 0xA5A5A5A5 then mtlo 0x5A5A5A5A on consecutive cycles -> hi=0xA5A5A5A5, lo=0x5A5A5A5A after the 2nd edge; busy=0 throughout.
- Start a div, assert ex_flush on the 10th DIV_RUN cycle -> busy=0 that cycle, state IDLE next, hi/lo retain their pre-div values, no div_done pulse.
- Start a div, pull rst_n low mid-run (asynchronous, between edges) -> hi=lo=0 and busy=0 immediately. A new divu 9/3 after release -> lo=3, hi=0.
